config_loader: RTL and testbench

CONFIG_LOADER -- requirements
Module: config_loader

---
 rtl/config_pkg.sv | 30 +++
 rtl/config_loader.sv | 105 ++++++++++
 tb/tb_config_loader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/config_pkg.sv
// Shared definitions for the configuration bitstream loader: FSM encoding,
// tile element type codes and interface defaults.
package config_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    localparam logic [15:0] CONFIG_SB  = 16'd7;
    localparam logic [15:0] CONFIG_CB0 = 16'd6;
    localparam logic [15:0] CONFIG_CB1 = 16'd5;
    localparam logic [15:0] CONFIG_CLB = 16'd4;

    localparam logic [15:0] CFG_TYPE_MIN = CONFIG_CLB;
    localparam logic [15:0] CFG_TYPE_MAX = CONFIG_SB;

    localparam logic [31:0] DEFAULT_IDLE_ADDR = 32'hFFFF_FFFF;
    localparam logic [15:0] DEFAULT_MAGIC     = 16'hC0F6;

    function automatic logic is_valid_type(input logic [15:0] elem_type);
        return (elem_type >= CFG_TYPE_MIN) && (elem_type <= CFG_TYPE_MAX);
    endfunction

endpackage

// File: rtl/config_loader.sv
// Parses a {MAGIC, N} header followed by N (address, data) pairs and
// broadcasts each pair to the tiles for exactly one cycle.
module config_loader
    import config_pkg::*;
#(
    parameter logic [31:0] IDLE_ADDR = DEFAULT_IDLE_ADDR,
    parameter logic [15:0] MAGIC     = DEFAULT_MAGIC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] write_count
);

    state_t      state_q, state_d;
    logic [15:0] remaining_q, remaining_d;
    logic [15:0] write_count_q, write_count_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            remaining_q   <= '0;
            write_count_q <= '0;
            addr_q        <= '0;
            data_q        <= '0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            write_count_q <= write_count_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        write_count_d = write_count_q;
        addr_d        = addr_q;
        data_d        = data_q;
        in_ready      = (state_q == ST_HEADER) || (state_q == ST_ADDR) || (state_q == ST_DATA);
        accept        = in_valid && in_ready;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d       = ST_HEADER;
                    write_count_d = '0;
                end
            end
            ST_HEADER: begin
                if (accept) begin
                    if (in_data[31:16] == MAGIC) begin
                        remaining_d = in_data[15:0];
                        state_d     = (in_data[15:0] == 16'd0) ? ST_DONE : ST_ADDR;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_ADDR: begin
                if (accept) begin
                    if (is_valid_type(in_data[31:16])) begin
                        addr_d  = in_data;
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    data_d  = in_data;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                remaining_d   = remaining_q - 16'd1;
                write_count_d = write_count_q + 16'd1;
                state_d       = (remaining_d == 16'd0) ? ST_DONE : ST_ADDR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Address is only driven during WRITE so idle cycles never alias a real tile.
    assign config_addr = (state_q == ST_WRITE) ? addr_q : IDLE_ADDR;
    assign config_data = data_q;
    assign busy        = in_ready || (state_q == ST_WRITE);
    assign done        = (state_q == ST_DONE);
    assign error       = (state_q == ST_ERROR);
    assign write_count = write_count_q;

endmodule

// File: tb/tb_config_loader.sv
// Scoreboard bench: a stream-level reference model predicts the write
// sequence and final status; a forked monitor checks every broadcast.
module tb_config_loader;

    localparam logic [31:0] IDLE_A = 32'hFFFF_FFFF;
    localparam logic [15:0] TAG    = 16'hC0F6;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] write_count;

    config_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .config_addr(config_addr),
        .config_data(config_data),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .write_count(write_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = -1;
    logic [63:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: walk the stream by the format rules; push expected writes.
    function automatic void model(input logic [31:0] s[$], output bit ok,
                                  output int consumed, output int nwr);
        logic [31:0] h, a;
        int n;
        ok = 1'b0; nwr = 0; consumed = 1;
        h = s[0];
        if (h[31:16] != TAG) return;
        n = int'(h[15:0]);
        for (int i = 0; i < n; i++) begin
            a = s[1 + 2 * i];
            consumed++;
            if (a[31:16] < 16'd4 || a[31:16] > 16'd7) return;
            consumed++;
            exp_q.push_back({a, s[2 + 2 * i]});
            nwr++;
        end
        ok = 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps, output bit acc);
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                tick();
            end
        end
        in_valid = 1'b1;
        in_data  = w;
        acc = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (in_ready) begin
                tick();
                accept_cyc = cyc;
                acc = 1'b1;
                break;
            end
            if (done || error) break;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        for (int k = 0; k < 20 && busy; k++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("wcount_cleared", {16'd0, write_count}, 32'd0);
    endtask

    task automatic run_load(input logic [31:0] s[$], input bit gaps, input string tag);
        bit ok, acc;
        int consumed, nwr, taken;
        model(s, ok, consumed, nwr);
        do_start();
        taken = 0;
        foreach (s[i]) begin
            send_word(s[i], gaps, acc);
            if (!acc) break;
            taken++;
        end
        for (int k = 0; k < 20 && !(done || error); k++) tick();
        check({tag, "_words_taken"}, taken, consumed);
        check({tag, "_done"}, {31'd0, done}, {31'd0, ok});
        check({tag, "_error"}, {31'd0, error}, {31'd0, !ok});
        check({tag, "_wcount"}, {16'd0, write_count}, nwr);
        check({tag, "_pending"}, exp_q.size(), 0);
        $display("load %s: words=%0d writes=%0d done=%0b error=%0b", tag, taken, write_count, done, error);
    endtask

    function automatic void rand_stream(output logic [31:0] s[$]);
        int mode, n, bad;
        logic [15:0] t;
        s = {};
        mode = $urandom_range(0, 3);
        n = (mode == 3) ? 0 : $urandom_range(1, 4);
        bad = $urandom_range(0, n > 0 ? n - 1 : 0);
        t = TAG;
        if (mode == 1) begin
            t = 16'($urandom);
            if (t == TAG) t = t ^ 16'h0001;
        end
        s.push_back({t, 16'(n)});
        for (int i = 0; i < n; i++) begin
            if (mode == 2 && i == bad)
                s.push_back({($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 3))
                                                         : 16'($urandom_range(8, 300)),
                             16'($urandom)});
            else
                s.push_back({16'(4 + $urandom_range(0, 3)), 16'($urandom)});
            s.push_back($urandom);
        end
    endfunction

    initial begin
        logic [31:0] s[$];
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;

        fork
            forever begin
                logic [63:0] e;
                @(negedge clk);
                if (!reset && config_addr !== IDLE_A) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", config_addr, IDLE_A);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", config_addr, e[63:32]);
                        check("wr_data", config_data, e[31:0]);
                        check("wr_latency", cyc, accept_cyc);
                        $display("write addr=%h data=%h", config_addr, config_data);
                    end
                end
            end
        join_none

        repeat (2) tick();
        check("rst_addr", config_addr, IDLE_A);
        check("rst_data", config_data, 32'd0);
        check("rst_wcount", {16'd0, write_count}, 32'd0);
        check("rst_flags", {28'd0, in_ready, busy, done, error}, 32'd0);
        reset = 1'b0;
        tick();

        s = {32'hC0F6_0002, 32'h0007_0003, 32'h0000_00AB, 32'h0004_0003, 32'h0000_0002};
        run_load(s, 1'b0, "basic");
        run_load(s, 1'b1, "gaps");
        s = {32'hC0F6_0000};
        run_load(s, 1'b0, "n0");
        s = {32'hBEEF_0001, 32'h0004_0001, 32'h0000_0011};
        run_load(s, 1'b0, "badtag");
        s = {32'hC0F6_0001, 32'h0006_0010, 32'h1234_5678};
        run_load(s, 1'b1, "recover");
        s = {32'hC0F6_0002, 32'h0009_0001, 32'h0000_0055, 32'h0004_0002, 32'h0000_0066};
        run_load(s, 1'b0, "badtype");

        for (int r = 0; r < 12; r++) begin
            rand_stream(s);
            run_load(s, ($urandom_range(0, 1) != 0), $sformatf("rand%0d", r));
        end

        // Reset during the WRITE of the first pair.
        do_start();
        s = {32'hC0F6_0002, 32'h0005_0001, 32'h0000_1234};
        exp_q.push_back({32'h0005_0001, 32'h0000_1234});
        foreach (s[i]) begin
            bit acc;
            send_word(s[i], 1'b0, acc);
        end
        @(negedge clk);
        #1 reset = 1'b1;
        tick();
        check("midrst_addr", config_addr, IDLE_A);
        check("midrst_data", config_data, 32'd0);
        check("midrst_wcount", {16'd0, write_count}, 32'd0);
        check("midrst_flags", {28'd0, in_ready, busy, done, error}, 32'd0);
        reset = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h0006_0002;
        repeat (8) tick();
        in_valid = 1'b0;
        check("midrst_pending", exp_q.size(), 0);
        check("midrst_idle", {31'd0, busy}, 32'd0);
        $display("load midreset: wcount=%0d busy=%0b", write_count, busy);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
